// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared widths, FSM states and default error data for the Wishbone memory arbiter
package wb_arb_pkg;
  localparam int XLEN  = 32;
  localparam int SEL_W = 4;
  localparam logic [XLEN-1:0] ERR_DATA_DEF = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, I_BUS, D_BUS, DONE} state_t;
endpackage

// File: rtl/wb_timeout_ctr.sv
// wb_timeout_ctr: counts bus cycles without acknowledge and flags the final allowed cycle
module wb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  logic [W-1:0] cnt_q;
  assign expired = enable && (cnt_q == W'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (clear) cnt_q <= '0;
    else if (enable && !expired) cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: serialises fetch and data requests onto one Wishbone B4 classic master port
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int               TIMEOUT_CYCLES = 255,
  parameter logic [XLEN-1:0]  ERR_DATA       = ERR_DATA_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [XLEN-1:0]   i_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [XLEN-1:0]   d_address,
  input  logic [XLEN-1:0]   mem_store,
  input  logic [SEL_W-1:0]  d_sel,
  output logic [XLEN-1:0]   instruction,
  output logic [XLEN-1:0]   memload,
  output logic              i_ack,
  output logic              d_ack,
  output logic              bus_err,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [XLEN-1:0]   wb_adr_o,
  output logic [XLEN-1:0]   wb_dat_o,
  output logic [SEL_W-1:0]  wb_sel_o,
  input  logic [XLEN-1:0]   wb_dat_i,
  input  logic              wb_ack_i
);
  state_t             state_q, state_d;
  logic               cyc_q, cyc_d, we_q, we_d;
  logic [XLEN-1:0]    adr_q, adr_d, dat_q, dat_d, instr_q, instr_d, load_q, load_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               i_ack_q, i_ack_d, d_ack_q, d_ack_d, err_q, err_d;
  logic               in_bus, expired, done;
  logic [XLEN-1:0]    rdata;

  assign in_bus = (state_q == I_BUS) || (state_q == D_BUS);
  // an ack arriving in the final allowed cycle wins over the timeout
  assign done   = in_bus && (wb_ack_i || expired);
  assign rdata  = wb_ack_i ? wb_dat_i : ERR_DATA;

  wb_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_bus),
    .enable (in_bus),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    instr_d = instr_q;
    load_d  = load_q;
    i_ack_d = 1'b0;
    d_ack_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_read || d_write) begin
          state_d = D_BUS;
          cyc_d   = 1'b1;
          we_d    = d_write;
          adr_d   = d_address;
          dat_d   = mem_store;
          sel_d   = d_write ? d_sel : '1;
        end else if (i_req) begin
          state_d = I_BUS;
          cyc_d   = 1'b1;
          we_d    = 1'b0;
          adr_d   = i_address;
          sel_d   = '1;
        end
      end
      I_BUS, D_BUS: begin
        if (done) begin
          state_d = DONE;
          cyc_d   = 1'b0;
          err_d   = !wb_ack_i;
          i_ack_d = (state_q == I_BUS);
          d_ack_d = (state_q == D_BUS);
          instr_d = (state_q == I_BUS) ? rdata : instr_q;
          load_d  = (state_q == D_BUS && !we_q) ? rdata : load_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      instr_q <= '0;
      load_q  <= '0;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      instr_q <= instr_d;
      load_q  <= load_d;
      i_ack_q <= i_ack_d;
      d_ack_q <= d_ack_d;
      err_q   <= err_d;
    end
  end

  assign instruction = instr_q;
  assign memload     = load_q;
  assign i_ack       = i_ack_q;
  assign d_ack       = d_ack_q;
  assign bus_err     = err_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb_wb_mem_arbiter: directed self-checking bench for the Wishbone memory arbiter
module tb_wb_mem_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        i_req = 1'b0, d_read = 1'b0, d_write = 1'b0, wb_ack_i = 1'b0;
  logic [31:0] i_address = '0, d_address = '0, mem_store = '0, wb_dat_i = '0;
  logic [3:0]  d_sel = '0;
  logic [31:0] instruction, memload, wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        i_ack, d_ack, bus_err, wb_cyc_o, wb_stb_o, wb_we_o;
  int          errors = 0, checks = 0;

  wb_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_address(i_address),
    .d_read(d_read), .d_write(d_write), .d_address(d_address),
    .mem_store(mem_store), .d_sel(d_sel), .instruction(instruction),
    .memload(memload), .i_ack(i_ack), .d_ack(d_ack), .bus_err(bus_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #2;
    chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_acks", {29'd0, i_ack, d_ack, bus_err}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    // zero-wait fetch
    i_req = 1'b1; i_address = 32'h0000_0040;
    chk("f_n_stb", {31'd0, wb_stb_o}, 32'd0);
    tick();
    chk("f_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd3);
    chk("f_adr", wb_adr_o, 32'h0000_0040);
    chk("f_we_sel", {27'd0, wb_we_o, wb_sel_o}, 32'h0000_000F);
    wb_ack_i = 1'b1; wb_dat_i = 32'h00A0_0093;
    tick();
    chk("f_iack", {30'd0, i_ack, d_ack}, 32'd2);
    chk("f_instr", instruction, 32'h00A0_0093);
    chk("f_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
    // spurious ack in DONE and then IDLE carries junk data
    i_req = 1'b0; wb_dat_i = 32'hBAD0_BAD0;
    tick();
    chk("sp_done_ack", {29'd0, i_ack, d_ack, bus_err}, 32'd0);
    chk("sp_done_instr", instruction, 32'h00A0_0093);
    tick();
    chk("sp_idle_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("sp_idle_ack", {30'd0, i_ack, d_ack}, 32'd0);
    chk("sp_idle_regs", instruction ^ memload, 32'h00A0_0093);
    wb_ack_i = 1'b0;
    // simultaneous fetch and load: data goes first
    i_req = 1'b1; i_address = 32'h0000_0044; d_read = 1'b1; d_address = 32'h0000_2000;
    tick();
    chk("s_adr_d", wb_adr_o, 32'h0000_2000);
    chk("s_we_sel", {27'd0, wb_we_o, wb_sel_o}, 32'h0000_000F);
    wb_ack_i = 1'b1; wb_dat_i = 32'h1111_2222;
    tick();
    chk("s_dack", {30'd0, i_ack, d_ack}, 32'd1);
    chk("s_memload", memload, 32'h1111_2222);
    wb_ack_i = 1'b0; d_read = 1'b0;
    tick();
    chk("s_idle_acks", {29'd0, i_ack, d_ack, wb_cyc_o}, 32'd0);
    tick();
    chk("s_adr_i", wb_adr_o, 32'h0000_0044);
    chk("s_stb_i", {31'd0, wb_stb_o}, 32'd1);
    wb_ack_i = 1'b1; wb_dat_i = 32'h0BAD_F00D;
    tick();
    chk("s_iack", {30'd0, i_ack, d_ack}, 32'd2);
    chk("s_instr", instruction, 32'h0BAD_F00D);
    wb_ack_i = 1'b0; i_req = 1'b0;
    tick();
    // store with three wait states
    d_write = 1'b1; d_address = 32'h0000_1000; mem_store = 32'hDEAD_BEEF; d_sel = 4'b0011;
    tick();
    chk("w_we_sel", {27'd0, wb_we_o, wb_sel_o}, 32'h0000_0013);
    chk("w_dat", wb_dat_o, 32'hDEAD_BEEF);
    chk("w_adr", wb_adr_o, 32'h0000_1000);
    mem_store = 32'h0; d_address = 32'hFFFF_FFFC;
    tick();
    tick();
    chk("w_wait_hold", {31'd0, d_ack}, 32'd0);
    chk("w_adr_hold", wb_adr_o, 32'h0000_1000);
    tick();
    wb_ack_i = 1'b1; wb_dat_i = 32'h5555_AAAA;
    tick();
    chk("w_dack", {29'd0, i_ack, d_ack, bus_err}, 32'd2);
    chk("w_memload", memload, 32'h1111_2222);
    wb_ack_i = 1'b0; d_write = 1'b0;
    tick();
    // silent slave on a load, 8-cycle timeout
    d_read = 1'b1; d_address = 32'h0000_3000;
    tick();
    for (int k = 0; k < 7; k++) tick();
    chk("t_cyc_c8", {31'd0, wb_cyc_o}, 32'd1);
    tick();
    chk("t_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
    chk("t_dack_err", {29'd0, i_ack, d_ack, bus_err}, 32'd3);
    chk("t_memload", memload, 32'h0000_0013);
    d_read = 1'b0;
    tick();
    chk("t_err_clr", {30'd0, d_ack, bus_err}, 32'd0);
    // reset during the second wait state of a fetch
    i_req = 1'b1; i_address = 32'h0000_0080;
    tick();
    tick();
    chk("r_cyc_pre", {31'd0, wb_cyc_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("r_cyc_async", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("r_instr_clr", instruction, 32'd0);
    i_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("r_no_iack", {29'd0, i_ack, d_ack, wb_cyc_o}, 32'd0);
    i_req = 1'b1; i_address = 32'h0000_0040;
    tick();
    chk("r2_adr", wb_adr_o, 32'h0000_0040);
    wb_ack_i = 1'b1; wb_dat_i = 32'h0010_0073;
    tick();
    chk("r2_iack", {30'd0, i_ack, d_ack}, 32'd2);
    chk("r2_instr", instruction, 32'h0010_0073);
    wb_ack_i = 1'b0; i_req = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
- Sits directly downstream of the core's request unit.
- Takes its instruction-fetch and data-access requests (i_address, d_address, mem_store, read/write strobes) and serialises them onto a single Wishbone B4 classic master port.
- Returns instruction, memload, i_ack and d_ack to the core.
- Owns arbitration, bus sequencing and a bus-timeout guard, so the core never hangs on an unresponsive slave.

Parameters:
- TIMEOUT_CYCLES, 255: bus cycles allowed without wb_ack_i before forced termination; legal range 2..65535.
- ERR_DATA, 32'h0000_0013: value returned on instruction/memload when a transfer times out (RISC-V NOP).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- i_req  in  1  instruction fetch request, level, held until i_ack
- i_address  in  32  fetch address
- d_read  in  1  data load request, level, held until d_ack
- d_write  in  1  data store request, level, held until d_ack
- d_address  in  32  load/store address
- mem_store  in  32  store data
- d_sel  in  4  byte enables for data access
- instruction  out  32  last fetched word, registered
- memload  out  32  last loaded word, registered
- i_ack  out  1  one-cycle pulse: fetch complete
- d_ack  out  1  one-cycle pulse: load/store complete
- bus_err  out  1  one-cycle pulse coincident with an ack that ended by timeout
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  Wishbone write enable
- wb_adr_o  out  32  Wishbone address
- wb_dat_o  out  32  Wishbone write data
- wb_sel_o  out  4  Wishbone byte selects
- wb_dat_i  in  32  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge

Behaviour:
- Reset (asynchronous, immediate): all outputs 0, including instruction and memload; state IDLE; timeout counter 0.
- Reset mid-transfer drops wb_cyc_o/wb_stb_o the same instant; no ack is issued for the aborted request.
- FSM states: IDLE, I_BUS, D_BUS, DONE.
- IDLE:
  - d_read|d_write -> D_BUS; data has priority over fetch when both are pending.
  - else i_req -> I_BUS.
  - Address, write data, sel and we are latched at this edge; wb_* outputs are registered and valid from the first BUS cycle.
- I_BUS: cyc=stb=1, we=0, sel=4'hF, adr=latched i_address.
- D_BUS: cyc=stb=1, we=d_write, sel=latched d_sel (4'hF for reads), adr=latched d_address, dat_o=latched mem_store.
  - d_read and d_write both high: treated as a write.
- BUS exit on wb_ack_i sampled high:
  - wb_cyc_o/wb_stb_o deassert next cycle.
  - Read data is captured into instruction (I_BUS) or memload (D_BUS).
  - Go to DONE.
- Timeout:
  - Counter clears on BUS entry and increments each BUS cycle without ack.
  - On reaching TIMEOUT_CYCLES-1: terminate the cycle, load ERR_DATA into the target register (memload untouched for writes), set bus_err, go to DONE.
- DONE (exactly one cycle):
  - i_ack or d_ack = 1 matching the completed request; bus_err if timed out.
  - Returns to IDLE unconditionally. The requester must drop its request in the cycle after the ack, so a held request is never re-issued.
- Latency: request first high in cycle N, zero-wait slave -> wb_stb_o high in N+1, ack seen at end of N+1, i_ack/d_ack high in N+2. Each slave wait state adds one cycle.
- A store leaves memload unchanged; instruction and memload hold their values between transfers.
- wb_ack_i while in IDLE or DONE is ignored.
- Address and data inputs are not sampled after the IDLE edge; changes mid-transfer have no effect.

Decomposition:
- Package wb_arb_pkg: state enum (IDLE, I_BUS, D_BUS, DONE), default ERR_DATA constant, width localparams (XLEN=32, SEL_W=4).
- Sub-module wb_timeout_ctr:
  - Ports: clk, rst, clear, enable, expired.
  - Counter width $clog2(TIMEOUT_CYCLES).
  - Instantiated once in wb_mem_arbiter.

Test Plan:
- Fetch, zero-wait slave returning 32'h00A00093 at i_address 32'h0000_0040: wb_adr_o=0x40, we=0; i_ack pulses in cycle N+2; instruction=0x00A00093.
- Store, d_write with d_address 32'h0000_1000, mem_store 32'hDEADBEEF, d_sel 4'b0011, slave with 3 wait states: wb_we_o=1, wb_sel_o=0011, wb_dat_o=0xDEADBEEF; d_ack in N+5; memload unchanged.
- Simultaneous i_req and d_read in the same IDLE cycle: D_BUS first, d_ack; then I_BUS, i_ack. Exactly one ack per request, never both in one cycle.
- Silent slave with TIMEOUT_CYCLES=8 on a load: cyc drops after 8 BUS cycles; d_ack and bus_err pulse together; memload=0x00000013.
- rst asserted during the 2nd wait state of a fetch: wb_cyc_o=0 immediately; no i_ack; after release, a fresh i_req completes normally.
- Spurious wb_ack_i in IDLE and DONE: no state change, no ack, registers unchanged.
